// File: rtl/horiz_move_ctrl_pkg.sv
// Shared types for the horizontal movement controller: FSM state codes,
// step direction, burst phase and button indices.
package horiz_move_ctrl_pkg;

  // State codes are also decoded by the vertical controller and the LED display.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  typedef enum logic {
    PH_PULSE = 1'b0,
    PH_GAP   = 1'b1
  } phase_t;

  localparam int BTN_L    = 0;
  localparam int BTN_R    = 1;
  localparam int BTN_C    = 2;
  localparam int NUM_BTNS = 3;

endpackage

// File: rtl/horiz_move_ctrl_if.sv
// Button, frame, counter-flag and command-pulse bundle between the
// environment (master) and the horizontal movement controller (slave).
interface horiz_move_ctrl_if;
  logic       btnL;
  logic       btnR;
  logic       btnC;
  logic       frame_tick;
  logic       at_right;
  logic       at_left;
  logic       game_over;
  logic       UP;
  logic       DW;
  logic       LD;
  logic       busy;
  logic       frame_missed;
  logic [2:0] state;

  modport master (
    output btnL, btnR, btnC, frame_tick, at_right, at_left, game_over,
    input  UP, DW, LD, busy, frame_missed, state
  );

  modport slave (
    input  btnL, btnR, btnC, frame_tick, at_right, at_left, game_over,
    output UP, DW, LD, busy, frame_missed, state
  );
endinterface

// File: rtl/horiz_move_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stability filter; level flips only after
// DEBOUNCE_CYCLES consecutive differing samples, and rise marks a 0->1 flip.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          rise_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
        level_reg <= sync2_reg;
        rise_reg  <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/horiz_move_ctrl.sv
// Turns debounced left/right/centre buttons and the frame tick into one-cycle
// UP/DW/LD pulses for the X-coordinate counter, stopping at the counter limits.
module horiz_move_ctrl
  import horiz_move_ctrl_pkg::*;
#(
  parameter int STEP_PER_FRAME  = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  horiz_move_ctrl_if.slave  bus
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_rise;

  assign btn_raw[BTN_L] = bus.btnL;
  assign btn_raw[BTN_R] = bus.btnR;
  assign btn_raw[BTN_C] = bus.btnC;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[gi]),
        .level (btn_level[gi]),
        .rise  (btn_rise[gi])
      );
    end
  endgenerate

  // Only the centre button uses its edge; left/right are consumed as levels.
  logic unused_btn;
  assign unused_btn = btn_rise[BTN_L] ^ btn_rise[BTN_R] ^ btn_level[BTN_C];

  logic   btn_l;
  logic   btn_r;
  logic   c_rise;
  assign btn_l  = btn_level[BTN_L];
  assign btn_r  = btn_level[BTN_R];
  assign c_rise = btn_rise[BTN_C];

  state_t     state_reg, state_next;
  phase_t     phase_reg, phase_next;
  dir_t       dir_reg, dir_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       limit_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      phase_reg <= PH_PULSE;
      dir_reg   <= DIR_DOWN;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign limit_hit = (dir_reg == DIR_UP) ? bus.at_right : bus.at_left;

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (c_rise) state_next = S_LOAD;
      end
      S_LOAD: begin
        state_next = bus.game_over ? S_HALT : S_RUN;
      end
      S_RUN: begin
        if (bus.game_over) begin
          state_next = S_HALT;
        end else if (c_rise) begin
          state_next = S_LOAD;
        end else if (bus.frame_tick) begin
          if (btn_r && !btn_l && !bus.at_right) begin
            state_next = S_STEP;
            dir_next   = DIR_UP;
            phase_next = PH_PULSE;
            cnt_next   = 4'(STEP_PER_FRAME);
          end else if (btn_l && !btn_r && !bus.at_left) begin
            state_next = S_STEP;
            dir_next   = DIR_DOWN;
            phase_next = PH_PULSE;
            cnt_next   = 4'(STEP_PER_FRAME);
          end
        end
      end
      S_STEP: begin
        if (bus.game_over) begin
          state_next = S_HALT;
        end else if (c_rise) begin
          state_next = S_LOAD;
        end else if (phase_reg == PH_PULSE) begin
          phase_next = PH_GAP;
          if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
        end else if (cnt_reg == 4'd0 || limit_hit) begin
          state_next = S_RUN;
        end else begin
          phase_next = PH_PULSE;
        end
      end
      S_HALT: begin
        if (c_rise) state_next = S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pulses decode from registered state so an async reset clears them at once.
  always_comb begin
    bus.UP           = 1'b0;
    bus.DW           = 1'b0;
    bus.LD           = 1'b0;
    bus.busy         = 1'b0;
    bus.frame_missed = 1'b0;
    case (state_reg)
      S_LOAD: begin
        bus.LD   = 1'b1;
        bus.busy = 1'b1;
      end
      S_STEP: begin
        bus.busy         = 1'b1;
        bus.frame_missed = bus.frame_tick;
        if (phase_reg == PH_PULSE && !bus.game_over) begin
          bus.UP = (dir_reg == DIR_UP);
          bus.DW = (dir_reg == DIR_DOWN);
        end
      end
      default: ;
    endcase
  end

  assign bus.state = state_reg;

endmodule

// File: tb/tb_horiz_move_ctrl.sv
// Scoreboard bench: expected UP/DW/LD pulses are queued as stimulus is driven
// and matched against pulses seen on the bus, with a simple X-counter model.
module tb_horiz_move_ctrl;

  localparam int SPF       = 4;
  localparam int DEB       = 4;
  localparam int RIGHT_LIM = 605;
  localparam int K_UP      = 1;
  localparam int K_DW      = 2;
  localparam int K_LD      = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   xpos = 0;
  int   load_val = 0;
  int   checks = 0;
  int   failures = 0;
  int   missed_seen = 0;
  exp_t exp_q[$];

  horiz_move_ctrl_if bus();

  horiz_move_ctrl #(
    .STEP_PER_FRAME  (SPF),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter model: the X-coordinate counter the pulses drive.
  always @(posedge clk) begin
    if (bus.LD) xpos <= load_val;
    else if (bus.UP) xpos <= xpos + 1;
    else if (bus.DW && xpos > 0) xpos <= xpos - 1;
  end

  assign bus.at_right = (xpos == RIGHT_LIM);
  assign bus.at_left  = (xpos == 0);

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void expect_pulse(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  // Monitor: every pulse seen must match the head of the scoreboard.
  always @(negedge clk) begin
    int   kind;
    exp_t e;
    if (bus.UP || bus.DW || bus.LD) begin
      kind = bus.UP ? K_UP : (bus.DW ? K_DW : K_LD);
      if (int'(bus.UP) + int'(bus.DW) + int'(bus.LD) > 1)
        check_eq("mutex", int'(bus.UP) + int'(bus.DW) + int'(bus.LD), 1);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", kind, 0);
      end else begin
        e = exp_q.pop_front();
        $display("txn cyc=%0d kind=%0d x=%0d", cyc, kind, xpos);
        check_eq("pulse_kind", kind, e.kind);
        if (e.cyc >= 0) check_eq("pulse_cycle", cyc, e.cyc);
      end
    end
    if (bus.frame_missed) missed_seen++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_c(input int new_load);
    load_val = new_load;
    expect_pulse(K_LD, -1);
    bus.btnC = 1'b1;
    wait_cycles(10);
    bus.btnC = 1'b0;
    wait_cycles(10);
  endtask

  task automatic tick(output int t);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic burst_expect(input int kind, input int t, input int n);
    for (int i = 0; i < n; i++) expect_pulse(kind, t + 1 + 2 * i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got %0d expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    bus.btnL = 1'b0;
    bus.btnR = 1'b0;
    bus.btnC = 1'b0;
    bus.frame_tick = 1'b0;
    bus.game_over = 1'b0;

    // Reset held with buttons toggling: everything stays quiet.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      bus.btnL = i[0];
      bus.btnR = i[1];
      bus.btnC = ~i[0];
      @(negedge clk);
      check_eq("rst_up", int'(bus.UP), 0);
      check_eq("rst_dw", int'(bus.DW), 0);
      check_eq("rst_ld", int'(bus.LD), 0);
      check_eq("rst_state", int'(bus.state), 0);
    end
    bus.btnL = 1'b0;
    bus.btnR = 1'b0;
    bus.btnC = 1'b0;
    reset = 1'b1;
    wait_cycles(12);
    check_eq("idle_after_rst", int'(bus.state), 0);

    // Start: one LD, then RUN at 600.
    press_c(600);
    check_eq("start_state", int'(bus.state), 2);
    check_eq("start_x", xpos, 600);
    check_eq("start_busy", int'(bus.busy), 0);

    // Right bursts into the limit.
    bus.btnR = 1'b1;
    wait_cycles(10);
    tick(t);
    burst_expect(K_UP, t, SPF);
    wait_cycles(12);
    check_eq("r1_x", xpos, 604);
    check_eq("r1_state", int'(bus.state), 2);
    tick(t);
    burst_expect(K_UP, t, 1);
    wait_cycles(8);
    check_eq("r2_x", xpos, RIGHT_LIM);
    check_eq("r2_state", int'(bus.state), 2);
    tick(t);
    wait_cycles(8);
    check_eq("r3_x", xpos, RIGHT_LIM);

    // Left at zero, then both buttons: no pulses.
    bus.btnR = 1'b0;
    press_c(0);
    check_eq("zero_x", xpos, 0);
    bus.btnL = 1'b1;
    wait_cycles(10);
    tick(t);
    wait_cycles(8);
    check_eq("l0_x", xpos, 0);
    press_c(10);
    bus.btnR = 1'b1;
    wait_cycles(10);
    tick(t);
    wait_cycles(8);
    check_eq("both_x", xpos, 10);

    // Left burst from 10.
    bus.btnR = 1'b0;
    wait_cycles(10);
    tick(t);
    burst_expect(K_DW, t, SPF);
    wait_cycles(12);
    check_eq("l1_x", xpos, 6);

    // Overlapping tick during a burst is dropped and flagged.
    missed_seen = 0;
    tick(t);
    burst_expect(K_DW, t, SPF);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    wait_cycles(12);
    check_eq("missed_cnt", missed_seen, 1);
    check_eq("ovl_x", xpos, 2);
    check_eq("ovl_state", int'(bus.state), 2);

    // game_over in the first pulse cycle suppresses it and halts.
    tick(t);
    bus.game_over = 1'b1;
    wait_cycles(1);
    check_eq("go_state", int'(bus.state), 4);
    wait_cycles(6);
    check_eq("go_x", xpos, 2);
    check_eq("go_busy", int'(bus.busy), 0);
    bus.game_over = 1'b0;
    press_c(300);
    check_eq("restart_state", int'(bus.state), 2);
    check_eq("restart_x", xpos, 300);

    // Reset mid-burst drops UP immediately.
    bus.btnL = 1'b0;
    bus.btnR = 1'b1;
    wait_cycles(10);
    tick(t);
    check_eq("pre_rst_up", int'(bus.UP), 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_up", int'(bus.UP), 0);
    check_eq("mid_rst_state", int'(bus.state), 0);
    wait_cycles(3);
    check_eq("mid_rst_x", xpos, 300);
    reset = 1'b1;
    wait_cycles(5);
    check_eq("post_rst_state", int'(bus.state), 0);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
